// File: rtl/seq_mul_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Default operand width
  localparam int unsigned WIDTH_DEFAULT = 8;

  // Iteration counter width: enough bits to hold the value WIDTH
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Datapath of the shift-add multiplier: operand magnitude capture,
// WIDTH+1-bit add with carry, {carry, acc, multiplier} right shift,
// and final sign fix into the product register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture operands (start accepted this edge)
//   step         perform one shift-add step this edge
//   finish       last step; write product this edge
//   signed_mode  1 = two's-complement operands
//   a, b         operands
//   product      result register, 2*WIDTH bits
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic             neg;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    full_c;

  // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned
  always_comb begin
    a_mag_c = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag_c = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // One step: conditional add into upper half, carry kept, then shift right
  always_comb begin
    sum_c  = {1'b0, acc} + ({1'b0, mcand} & {(WIDTH+1){mplier[0]}});
    full_c = {sum_c, mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      mcand  <= a_mag_c;
      mplier <= b_mag_c;
      acc    <= '0;
      neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= full_c[PW-1:WIDTH];
      mplier <= full_c[WIDTH-1:0];
      // Negating zero yields zero, so no negative-zero special case
      if (finish) begin
        product <= neg ? (~full_c + PW'(1)) : full_c;
      end
    end
  end

endmodule

// File: rtl/seq_mul_n.sv
// Parametrised sequential shift-add multiplier, WIDTH steps per operation,
// unsigned or two's-complement per operation, start/busy/done handshake.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled on rising edge when not busy
//   signed_mode  1 = signed operands (captured with start)
//   a, b         operands (captured with start)
//   busy         high while iterating
//   done         one-cycle completion pulse
//   product      result, held until next completion
module seq_mul_n
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic accept_c;
  logic step_c;
  logic finish_c;

  // Start is honoured in IDLE and in DONE (back-to-back), never in RUN
  always_comb begin
    accept_c = start && ((state == IDLE) || (state == DONE));
    step_c   = (state == RUN);
    finish_c = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  end

  // Controller with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept_c) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (finish_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (accept_c) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept_c),
    .step        (step_c),
    .finish      (finish_c),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .product     (product)
  );

endmodule
